// File: rtl/fetch_engine_if.sv
// fetch_engine_if -- groups the request, cache-memory and external burst
// signals of the line fetch engine. The engine connects through the slave
// modport; whatever issues requests and models the memories uses master.
interface fetch_engine_if #(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int data_width = 32,
    parameter int list_width = 32
);
    localparam int tag_w   = $clog2(list_depth);
    localparam int maddr_w = $clog2(list_depth) + $clog2(list_width);

    logic                  fetch_req;
    logic [1:0]            fetch_cmd;
    logic [tag_w-1:0]      fetch_tag;
    logic [addr_width-1:0] fetch_addr;
    logic                  fetch_gnt;
    logic                  fetch_done;

    logic                  mem_ren;
    logic [maddr_w-1:0]    mem_raddr;
    logic                  mem_rready;
    logic                  mem_rvalid;
    logic [data_width-1:0] mem_rdata;

    logic                  mem_wen;
    logic [maddr_w-1:0]    mem_waddr;
    logic [data_width-1:0] mem_wdata;
    logic [1:0]            mem_wpri;
    logic                  mem_wready;

    logic                  ext_req;
    logic                  ext_we;
    logic [addr_width-1:0] ext_addr;
    logic                  ext_gnt;
    logic                  ext_wvalid;
    logic [data_width-1:0] ext_wdata;
    logic                  ext_wready;
    logic                  ext_rvalid;
    logic [data_width-1:0] ext_rdata;
    logic                  ext_rready;

    modport master (
        output fetch_req, fetch_cmd, fetch_tag, fetch_addr,
        input  fetch_gnt, fetch_done,
        input  mem_ren, mem_raddr,
        output mem_rready, mem_rvalid, mem_rdata,
        input  mem_wen, mem_waddr, mem_wdata, mem_wpri,
        output mem_wready,
        input  ext_req, ext_we, ext_addr,
        output ext_gnt,
        input  ext_wvalid, ext_wdata,
        output ext_wready, ext_rvalid, ext_rdata,
        input  ext_rready
    );

    modport slave (
        input  fetch_req, fetch_cmd, fetch_tag, fetch_addr,
        output fetch_gnt, fetch_done,
        output mem_ren, mem_raddr,
        input  mem_rready, mem_rvalid, mem_rdata,
        output mem_wen, mem_waddr, mem_wdata, mem_wpri,
        input  mem_wready,
        output ext_req, ext_we, ext_addr,
        input  ext_gnt,
        output ext_wvalid, ext_wdata,
        input  ext_wready, ext_rvalid, ext_rdata,
        output ext_rready
    );
endinterface

// File: rtl/fetch_engine.sv
// fetch_engine -- moves one cache line at a time between the cache data
// memory and an external burst bus: writeback (cache -> ext) or fill
// (ext -> cache), through a one-entry beat buffer.
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
// perf_wb_cnt / perf_fill_cnt completion counters.
module fetch_engine #(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int data_width = 32,
    parameter int list_width = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_engine_if.slave bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]   perf_wb_cnt,
    output logic [15:0]   perf_fill_cnt
`endif
);
    localparam int tag_w   = $clog2(list_depth);
    localparam int beat_w  = $clog2(list_width);
    localparam int cnt_w   = beat_w + 1;
    localparam int maddr_w = tag_w + beat_w;
    localparam int off_w   = $clog2(list_width * data_width / 8);

    localparam logic [cnt_w-1:0]      last_beat  = cnt_w'(list_width - 1);
    localparam logic [cnt_w-1:0]      beat_total = cnt_w'(list_width);
    localparam logic [addr_width-1:0] line_mask  = {addr_width{1'b1}} << off_w;

    typedef enum logic [2:0] {
        IDLE,
        WB_ADDR,
        WB_DATA,
        FILL_ADDR,
        FILL_DATA,
        DONE
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [tag_w-1:0]      tag_q;
    logic [1:0]            cmd_q;
    logic [addr_width-1:0] line_q;
    logic [cnt_w-1:0]      rd_beat;
    logic [cnt_w-1:0]      wr_beat;
    logic                  buf_full;
    logic [data_width-1:0] buf_data;
    logic                  rd_pending;

    logic                  handshake;
    logic                  burst_start;
    logic                  rd_accept;
    logic                  rd_return;
    logic                  buf_load;
    logic                  buf_drain;

    // Next state, bus outputs and internal handshake strobes; everything is
    // forced to its idle value while rst is high so reset looks clean at once.
    always_comb begin
        state_n        = state;
        handshake      = 1'b0;
        burst_start    = 1'b0;
        rd_accept      = 1'b0;
        rd_return      = 1'b0;
        buf_load       = 1'b0;
        buf_drain      = 1'b0;
        bus.fetch_gnt  = 1'b0;
        bus.fetch_done = 1'b0;
        bus.mem_ren    = 1'b0;
        bus.mem_raddr  = '0;
        bus.mem_wen    = 1'b0;
        bus.mem_waddr  = '0;
        bus.mem_wdata  = '0;
        bus.mem_wpri   = 2'b00;
        bus.ext_req    = 1'b0;
        bus.ext_we     = 1'b0;
        bus.ext_addr   = '0;
        bus.ext_wvalid = 1'b0;
        bus.ext_wdata  = '0;
        bus.ext_rready = 1'b0;

        if (rst) begin
            bus.fetch_gnt = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bus.fetch_gnt = 1'b1;
                    handshake     = bus.fetch_req;
                    if (bus.fetch_req) begin
                        case (bus.fetch_cmd)
                            2'b00:   state_n = WB_ADDR;
                            2'b01:   state_n = FILL_ADDR;
                            default: state_n = DONE;
                        endcase
                    end
                end
                WB_ADDR, FILL_ADDR: begin
                    bus.ext_req  = 1'b1;
                    bus.ext_we   = (cmd_q == 2'b00);
                    bus.ext_addr = line_q;
                    burst_start  = bus.ext_gnt;
                    if (bus.ext_gnt) begin
                        state_n = (state == WB_ADDR) ? WB_DATA : FILL_DATA;
                    end
                end
                WB_DATA: begin
                    bus.mem_ren = !buf_full && !rd_pending && (rd_beat < beat_total);
                    if (bus.mem_ren) begin
                        bus.mem_raddr = {tag_q, rd_beat[beat_w-1:0]};
                    end
                    rd_accept      = bus.mem_ren && bus.mem_rready;
                    rd_return      = bus.mem_rvalid;
                    buf_load       = bus.mem_rvalid && !buf_full;
                    bus.ext_wvalid = buf_full;
                    if (buf_full) begin
                        bus.ext_wdata = buf_data;
                    end
                    buf_drain = buf_full && bus.ext_wready;
                    if (buf_drain && (wr_beat == last_beat)) begin
                        state_n = DONE;
                    end
                end
                FILL_DATA: begin
                    bus.ext_rready = !buf_full;
                    buf_load       = bus.ext_rvalid && !buf_full;
                    bus.mem_wen    = buf_full;
                    if (buf_full) begin
                        bus.mem_waddr = {tag_q, wr_beat[beat_w-1:0]};
                        bus.mem_wdata = buf_data;
                        bus.mem_wpri  = 2'b01;
                    end
                    buf_drain = buf_full && bus.mem_wready;
                    if (buf_drain && (wr_beat == last_beat)) begin
                        state_n = DONE;
                    end
                end
                DONE: begin
                    bus.fetch_done = 1'b1;
                    state_n        = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State register, captured request fields, beat counters and the
    // one-entry buffer; a new burst always starts from an empty buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tag_q      <= '0;
            cmd_q      <= '0;
            line_q     <= '0;
            rd_beat    <= '0;
            wr_beat    <= '0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            rd_pending <= 1'b0;
        end else begin
            state <= state_n;
            if (handshake) begin
                tag_q  <= bus.fetch_tag;
                cmd_q  <= bus.fetch_cmd;
                line_q <= bus.fetch_addr & line_mask;
            end
            if (burst_start) begin
                rd_beat    <= '0;
                wr_beat    <= '0;
                buf_full   <= 1'b0;
                rd_pending <= 1'b0;
            end else begin
                if (rd_accept) begin
                    rd_beat    <= rd_beat + cnt_w'(1);
                    rd_pending <= 1'b1;
                end
                if (rd_return) begin
                    rd_pending <= 1'b0;
                end
                if (buf_load) begin
                    buf_full <= 1'b1;
                    buf_data <= (state == WB_DATA) ? bus.mem_rdata : bus.ext_rdata;
                end else if (buf_drain) begin
                    buf_full <= 1'b0;
                    wr_beat  <= wr_beat + cnt_w'(1);
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count completed writebacks and fills on entry to DONE, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wb_cnt   <= '0;
            perf_fill_cnt <= '0;
        end else begin
            if ((state == WB_DATA) && (state_n == DONE) && (perf_wb_cnt != 16'hFFFF)) begin
                perf_wb_cnt <= perf_wb_cnt + 16'd1;
            end
            if ((state == FILL_DATA) && (state_n == DONE) && (perf_fill_cnt != 16'hFFFF)) begin
                perf_fill_cnt <= perf_fill_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_engine.sv
// tb_fetch_engine -- directed bench for fetch_engine with list_width=4,
// list_depth=4. Memory and external bus responders run once per cycle inside
// applyStimulus; expected beats are queued when a transfer is set up and
// popped as the engine produces them.
module tb_fetch_engine;
    localparam int AW = 32;
    localparam int LD = 4;
    localparam int DW = 32;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_engine_if #(.addr_width(AW), .list_depth(LD), .data_width(DW), .list_width(LW)) fif ();

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_wb_cnt;
    logic [15:0] perf_fill_cnt;
`endif

    fetch_engine #(.addr_width(AW), .list_depth(LD), .data_width(DW), .list_width(LW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(fif)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_wb_cnt(perf_wb_cnt),
        .perf_fill_cnt(perf_fill_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_data [16];
    logic        read_pending;
    logic [31:0] read_data;
    logic [31:0] fill_q [$];
    logic [3:0]  exp_waddr_q [$];
    logic [31:0] exp_fdata_q [$];
    logic [3:0]  exp_raddr_q [$];
    logic [31:0] exp_wdata_q [$];
    logic [31:0] exp_ext_addr;
    logic        exp_ext_we;
    int          stall_beat;
    int          stall_left;
    int          memw_stall_left;
    int          wb_beats;
    int          mem_writes;
    int          done_count;
    int          cycle;
    int          last_done_cycle;
    int          last_grant_cycle;
    logic        granted;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    // One clock cycle: sample outputs at the falling edge, answer as the
    // memories and external bus would, then let the rising edge happen.
    task automatic applyStimulus();
        @(negedge clk);
        cycle++;
        granted = 1'b0;
        if (fif.fetch_req && fif.fetch_gnt && !rst) begin
            granted          = 1'b1;
            last_grant_cycle = cycle;
        end
        if (fif.fetch_done) begin
            done_count++;
            last_done_cycle = cycle;
        end

        fif.ext_gnt = fif.ext_req;
        if (fif.ext_req) begin
            checkOutput("ext_addr", 64'(fif.ext_addr), 64'(exp_ext_addr));
            checkOutput("ext_we", 64'(fif.ext_we), 64'(exp_ext_we));
        end

        fif.mem_rready = 1'b1;
        fif.mem_rvalid = read_pending;
        fif.mem_rdata  = read_pending ? read_data : 32'h0;
        read_pending   = 1'b0;
        if (fif.mem_ren) begin
            if (exp_raddr_q.size() == 0) checkOutput("raddr_extra", 64'd1, 64'd0);
            else checkOutput("mem_raddr", 64'(fif.mem_raddr), 64'(exp_raddr_q.pop_front()));
            read_pending = 1'b1;
            read_data    = mem_data[fif.mem_raddr];
        end

        fif.ext_wready = 1'b1;
        if (fif.ext_wvalid) begin
            if (wb_beats == stall_beat && stall_left > 0) begin
                fif.ext_wready = 1'b0;
                stall_left--;
            end else begin
                if (exp_wdata_q.size() == 0) checkOutput("wdata_extra", 64'd1, 64'd0);
                else checkOutput("ext_wdata", 64'(fif.ext_wdata), 64'(exp_wdata_q.pop_front()));
                wb_beats++;
            end
        end

        fif.ext_rvalid = (fill_q.size() > 0);
        fif.ext_rdata  = (fill_q.size() > 0) ? fill_q[0] : 32'h0;
        if (fif.ext_rvalid && fif.ext_rready) void'(fill_q.pop_front());

        fif.mem_wready = 1'b1;
        if (fif.mem_wen) begin
            checkOutput("rready_while_full", 64'(fif.ext_rready), 64'd0);
            checkOutput("mem_wpri", 64'(fif.mem_wpri), 64'd1);
            if (memw_stall_left > 0) begin
                fif.mem_wready = 1'b0;
                memw_stall_left--;
            end else begin
                if (exp_waddr_q.size() == 0) checkOutput("mem_write_extra", 64'd1, 64'd0);
                else begin
                    checkOutput("mem_waddr", 64'(fif.mem_waddr), 64'(exp_waddr_q.pop_front()));
                    checkOutput("mem_wdata", 64'(fif.mem_wdata), 64'(exp_fdata_q.pop_front()));
                end
                mem_writes++;
            end
        end else begin
            checkOutput("mem_wpri_idle", 64'(fif.mem_wpri), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        checkOutput({tag, "_gnt"}, 64'(fif.fetch_gnt), 64'd1);
        checkOutput({tag, "_done"}, 64'(fif.fetch_done), 64'd0);
        checkOutput({tag, "_ext_req"}, 64'(fif.ext_req), 64'd0);
        checkOutput({tag, "_ext_wvalid"}, 64'(fif.ext_wvalid), 64'd0);
        checkOutput({tag, "_ext_rready"}, 64'(fif.ext_rready), 64'd0);
        checkOutput({tag, "_mem_ren"}, 64'(fif.mem_ren), 64'd0);
        checkOutput({tag, "_mem_wen"}, 64'(fif.mem_wen), 64'd0);
        checkOutput({tag, "_addr_data"},
                    {16'h0, 4'(fif.mem_raddr), 4'(fif.mem_waddr), fif.mem_wdata | fif.ext_wdata | fif.ext_addr},
                    64'd0);
    endtask

    task automatic start_fill(input logic [1:0] tag, input logic [31:0] addr, input logic [31:0] base);
        exp_ext_addr = addr & 32'hFFFF_FFF0;
        exp_ext_we   = 1'b0;
        for (int i = 0; i < LW; i++) begin
            fill_q.push_back(base + 32'(i));
            exp_waddr_q.push_back({tag, 2'(i)});
            exp_fdata_q.push_back(base + 32'(i));
        end
    endtask

    task automatic request(input logic [1:0] cmd, input logic [1:0] tag, input logic [31:0] addr);
        fif.fetch_req  = 1'b1;
        fif.fetch_cmd  = cmd;
        fif.fetch_tag  = tag;
        fif.fetch_addr = addr;
        for (int n = 0; n < 60; n++) begin
            applyStimulus();
            if (granted) break;
        end
        checkOutput("grant_seen", 64'(granted), 64'd1);
        fif.fetch_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start;
        start = done_count;
        for (int n = 0; n < 200; n++) begin
            applyStimulus();
            if (done_count != start) break;
        end
        for (int n = 0; n < 3; n++) applyStimulus();
        checkOutput({tag, "_done_pulses"}, 64'(done_count - start), 64'd1);
    endtask

    initial begin
        int w0;
        rst              = 1'b1;
        fif.fetch_req    = 1'b0;
        fif.fetch_cmd    = 2'b00;
        fif.fetch_tag    = 2'd0;
        fif.fetch_addr   = 32'h0;
        fif.mem_rready   = 1'b0;
        fif.mem_rvalid   = 1'b0;
        fif.mem_rdata    = 32'h0;
        fif.mem_wready   = 1'b0;
        fif.ext_gnt      = 1'b0;
        fif.ext_wready   = 1'b0;
        fif.ext_rvalid   = 1'b0;
        fif.ext_rdata    = 32'h0;
        read_pending     = 1'b0;
        read_data        = 32'h0;
        exp_ext_addr     = 32'h0;
        exp_ext_we       = 1'b0;
        stall_beat       = -1;
        stall_left       = 0;
        memw_stall_left  = 0;
        wb_beats         = 0;
        mem_writes       = 0;
        done_count       = 0;
        cycle            = 0;
        last_done_cycle  = 0;
        last_grant_cycle = 0;
        granted          = 1'b0;
        for (int i = 0; i < 16; i++) mem_data[i] = 32'hD15C_0000 | (32'(i) * 32'h0101);

        $display("[TB] reset");
        applyStimulus();
        applyStimulus();
        check_idle("in_reset");
        rst = 1'b0;
        check_idle("after_reset");

        $display("[TB] fill tag 2 addr 0x1234");
        w0 = mem_writes;
        start_fill(2'd2, 32'h0000_1234, 32'hA0A0_0000);
        request(2'b01, 2'd2, 32'h0000_1234);
        wait_done("fill1");
        checkOutput("fill1_writes", 64'(mem_writes - w0), 64'd4);
        checkOutput("fill1_queue", 64'(exp_waddr_q.size()), 64'd0);

        $display("[TB] writeback tag 1 with ext_wready stall on beat 2");
        w0 = wb_beats;
        exp_ext_addr = 32'h0000_2340;
        exp_ext_we   = 1'b1;
        for (int i = 4; i < 8; i++) begin
            exp_raddr_q.push_back(4'(i));
            exp_wdata_q.push_back(mem_data[i]);
        end
        stall_beat = w0 + 2;
        stall_left = 3;
        request(2'b00, 2'd1, 32'h0000_2345);
        wait_done("wb");
        checkOutput("wb_beats", 64'(wb_beats - w0), 64'd4);
        checkOutput("wb_rd_queue", 64'(exp_raddr_q.size()), 64'd0);
        checkOutput("wb_wr_queue", 64'(exp_wdata_q.size()), 64'd0);
        checkOutput("wb_stall_used", 64'(stall_left), 64'd0);

        $display("[TB] fill with mem_wready low for 5 cycles");
        w0 = mem_writes;
        memw_stall_left = 5;
        start_fill(2'd0, 32'h0000_0080, 32'hB0B0_0000);
        request(2'b01, 2'd0, 32'h0000_0080);
        wait_done("fill_bp");
        checkOutput("fill_bp_writes", 64'(mem_writes - w0), 64'd4);
        checkOutput("fill_bp_stall_used", 64'(memw_stall_left), 64'd0);

        $display("[TB] request held high during a busy fill");
        start_fill(2'd3, 32'h0000_0100, 32'hC0C0_0000);
        request(2'b01, 2'd3, 32'h0000_0100);
        w0 = done_count;
        fif.fetch_req = 1'b1;
        fif.fetch_cmd = 2'b10;
        fif.fetch_tag = 2'd0;
        for (int n = 0; n < 200; n++) begin
            applyStimulus();
            if (granted) break;
        end
        fif.fetch_req = 1'b0;
        checkOutput("busy_done_before_grant", 64'(done_count - w0), 64'd1);
        checkOutput("busy_grant_after_done", 64'(last_grant_cycle), 64'(last_done_cycle + 1));
        wait_done("null_after_busy");
        checkOutput("null_done_latency", 64'(last_done_cycle), 64'(last_grant_cycle + 1));

`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fill", 64'(perf_fill_cnt), 64'd3);
        checkOutput("perf_wb", 64'(perf_wb_cnt), 64'd1);
`endif

        $display("[TB] reset during beat 2 of a fill");
        w0 = mem_writes;
        start_fill(2'd2, 32'h0000_0200, 32'hE0E0_0000);
        request(2'b01, 2'd2, 32'h0000_0200);
        for (int n = 0; n < 100; n++) begin
            applyStimulus();
            if (mem_writes - w0 >= 2) break;
        end
        checkOutput("abort_two_writes", 64'(mem_writes - w0), 64'd2);
        w0 = done_count;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        fill_q.delete();
        exp_waddr_q.delete();
        exp_fdata_q.delete();
        read_pending = 1'b0;
        check_idle("post_abort");
        for (int n = 0; n < 5; n++) applyStimulus();
        checkOutput("abort_no_done", 64'(done_count - w0), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fill_cleared", 64'(perf_fill_cnt), 64'd0);
        checkOutput("perf_wb_cleared", 64'(perf_wb_cnt), 64'd0);
`endif
        request(2'b11, 2'd0, 32'h0000_0000);
        wait_done("null_after_abort");
        checkOutput("null_after_abort_latency", 64'(last_done_cycle), 64'(last_grant_cycle + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
